// File: rtl/sprite_plotter_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_plotter_if
// Brief    : Bundle of the start/done handshake, the sprite ROM port and the VGA plot port
// Revision : 1.0
// ============================================================================
interface sprite_plotter_if #(
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [7:0]          x_base;
    logic [6:0]          y_base;
    logic [10:0]         rom_addr;
    logic [COLOUR_W-1:0] rom_data;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                busy;
    logic                done;

    modport master (
        output start, x_base, y_base, rom_data,
        input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  start, x_base, y_base, rom_data,
        output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_plotter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_plotter
// Brief    : Self-timed sprite blit: walks the sprite ROM, pairs each colour with
//            its screen coordinate and strobes the VGA plot port, clipping at the
//            screen edges. Optional macro: SPRITE_PLOTTER_TRANSPARENCY_EN.
// Revision : 1.0
// ============================================================================
module sprite_plotter #(
    parameter int SPRITE_W        = 40,
    parameter int SPRITE_H        = 40,
    parameter int SCREEN_W        = 160,
    parameter int SCREEN_H        = 120,
    parameter int ROM_LATENCY     = 1,
    parameter int COLOUR_W        = 3,
    parameter int TRANSPARENT_KEY = 0
) (
    input  logic             clk,
    input  logic             resetn,
    sprite_plotter_if.slave  bus
);
    localparam int c_COL_W = $clog2(SPRITE_W);
    localparam int c_ROW_W = $clog2(SPRITE_H);
    localparam int c_LAST  = SPRITE_W * SPRITE_H - 1;
    localparam int c_STG_W = 1 + 8 + 7;
    localparam logic [COLOUR_W-1:0] c_KEY = COLOUR_W'(TRANSPARENT_KEY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [7:0]           r_xb;
    logic [6:0]           r_yb;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic [10:0]          r_rom_addr;
    logic [2:0]           r_drain;
    logic                 r_busy;
    logic                 r_done;

    logic [ROM_LATENCY:1][c_STG_W-1:0] r_pipe;

    logic [7:0]           r_vga_x;
    logic [6:0]           r_vga_y;
    logic [COLOUR_W-1:0]  r_vga_colour;
    logic                 r_vga_plot;

    logic [8:0]           w_x;
    logic [7:0]           w_y;
    logic                 w_vis;
    logic [c_STG_W-1:0]   w_tail;
    logic                 w_opaque;

    // Coordinates are widened by one bit so sprites hanging off the edge clip instead of wrapping.
    assign w_x    = {1'b0, r_xb} + 9'(r_col);
    assign w_y    = {1'b0, r_yb} + 8'(r_row);
    assign w_vis  = (r_state == S_FETCH) && (w_x < 9'(SCREEN_W)) && (w_y < 8'(SCREEN_H));
    assign w_tail = r_pipe[ROM_LATENCY];

`ifdef SPRITE_PLOTTER_TRANSPARENCY_EN
    assign w_opaque = (bus.rom_data != c_KEY);
`else
    // Key is deliberately ignored in this build; the expression folds to constant 1.
    assign w_opaque = (bus.rom_data == c_KEY) || 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_xb       <= '0;
            r_yb       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_rom_addr <= '0;
            r_drain    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_xb       <= bus.x_base;
                        r_yb       <= bus.y_base;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_rom_addr <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_rom_addr == 11'(c_LAST)) begin
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_rom_addr <= r_rom_addr + 11'd1;
                        if (r_col == c_COL_W'(SPRITE_W - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Holds until the last pixel has left the output register.
                    if (r_drain == 3'(ROM_LATENCY)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pipe <= '0;
        end else begin
            r_pipe[1] <= {w_vis, w_x[7:0], w_y[6:0]};
            for (int i = 2; i <= ROM_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_vga_plot <= w_tail[c_STG_W-1] && w_opaque;
            if (w_tail[c_STG_W-1]) begin
                r_vga_x      <= w_tail[14:7];
                r_vga_y      <= w_tail[6:0];
                r_vga_colour <= bus.rom_data;
            end
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_colour;
    assign bus.vga_plot   = r_vga_plot;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_sprite_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_plotter
// Brief    : Scoreboard bench driving a latency-1 and a latency-3 plotter side by side
// Revision : 1.0
// ============================================================================
module tb_sprite_plotter;
    localparam int SW   = 40;
    localparam int SH   = 40;
    localparam int NPIX = SW * SH;

    typedef struct {
        int cyc;
        int x;
        int y;
        int col;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  x_base;
    logic [6:0]  y_base;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [2:0]  rom_mem [0:2047];
    exp_t        exp_q  [2][$];
    int          done_q [2][$];
    int          b_lo [2];
    int          b_hi [2];
    int          n_plot [2];
    int          exp_n [2];
    logic [1:0]  outs_zero;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar I = 0; I < 2; I++) begin : g_dut
        localparam int L = (I == 0) ? 1 : 3;
        sprite_plotter_if #(.COLOUR_W(3)) bus ();
        logic [2:0] rp [0:L-1];

        assign bus.start    = start;
        assign bus.x_base   = x_base;
        assign bus.y_base   = y_base;
        assign bus.rom_data = rp[L-1];
        assign outs_zero[I] = (bus.rom_addr == 0) && (bus.vga_x == 0) && (bus.vga_y == 0) &&
                              (bus.vga_colour == 0) && !bus.vga_plot && !bus.busy && !bus.done;

        sprite_plotter #(.ROM_LATENCY(L)) dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (bus)
        );

        always @(posedge clk) begin
            rp[0] <= rom_mem[bus.rom_addr];
            for (int j = 1; j < L; j++) rp[j] <= rp[j-1];
        end

        always @(negedge clk) begin
            exp_t e;
            int   d;
            logic want_busy;
            if (!resetn) begin
                n_cmp++;
                if (!outs_zero[I]) begin
                    n_fail++;
                    $display("FAIL reset_outputs lat=%0d got plot=%0b busy=%0b done=%0b addr=%0d want all zero",
                             L, bus.vga_plot, bus.busy, bus.done, bus.rom_addr);
                end
                exp_q[I].delete();
                done_q[I].delete();
            end else begin
                want_busy = (cyc >= b_lo[I]) && (cyc <= b_hi[I]);
                n_cmp++;
                if (bus.busy !== want_busy) begin
                    n_fail++;
                    $display("FAIL busy lat=%0d cyc=%0d got %0b want %0b", L, cyc, bus.busy, want_busy);
                end
                if (bus.vga_plot) begin
                    n_plot[I]++;
                    n_cmp++;
                    if (exp_q[I].size() == 0) begin
                        n_fail++;
                        $display("FAIL plot_unexpected lat=%0d cyc=%0d got (%0d,%0d) c%0d want no plot",
                                 L, cyc, bus.vga_x, bus.vga_y, bus.vga_colour);
                    end else begin
                        e = exp_q[I].pop_front();
                        if (cyc != e.cyc || bus.vga_x != e.x || bus.vga_y != e.y || bus.vga_colour != e.col) begin
                            n_fail++;
                            $display("FAIL plot lat=%0d got cyc=%0d (%0d,%0d) c%0d want cyc=%0d (%0d,%0d) c%0d",
                                     L, cyc, bus.vga_x, bus.vga_y, bus.vga_colour, e.cyc, e.x, e.y, e.col);
                        end
                    end
                end
                if (bus.done) begin
                    n_cmp++;
                    if (done_q[I].size() == 0) begin
                        n_fail++;
                        $display("FAIL done_unexpected lat=%0d got done at cyc=%0d want none", L, cyc);
                    end else begin
                        d = done_q[I].pop_front();
                        if (d != cyc) begin
                            n_fail++;
                            $display("FAIL done_cycle lat=%0d got %0d want %0d", L, cyc, d);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Reference model: enumerate the sprite in row-major order and predict every visible plot.
    task automatic issue(input int xb, input int yb, output int c);
        int   l;
        int   x;
        int   y;
        bit   show;
        exp_t e;
        step();
        start  = 1'b1;
        x_base = 8'(xb);
        y_base = 7'(yb);
        c      = cyc;
        for (int i = 0; i < 2; i++) begin
            l        = (i == 0) ? 1 : 3;
            n_plot[i] = 0;
            exp_n[i]  = 0;
            for (int k = 0; k < NPIX; k++) begin
                x    = xb + k % SW;
                y    = yb + k / SW;
                show = (x < 160) && (y < 120);
`ifdef SPRITE_PLOTTER_TRANSPARENCY_EN
                if (rom_mem[k] == 3'd0) show = 1'b0;
`endif
                if (show) begin
                    e.cyc = c + k + l + 2;
                    e.x   = x;
                    e.y   = y;
                    e.col = int'(rom_mem[k]);
                    exp_q[i].push_back(e);
                    exp_n[i]++;
                end
            end
            done_q[i].push_back(c + NPIX + l + 2);
            b_lo[i] = c + 1;
            b_hi[i] = c + NPIX + l + 1;
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int t;
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + done_q[0].size() + done_q[1].size()) != 0 && t < 4000) begin
            step();
            t++;
        end
        n_cmp++;
        if (t >= 4000) begin
            n_fail++;
            $display("FAIL %s_timeout got %0d pending items want 0",
                     tag, exp_q[0].size() + exp_q[1].size() + done_q[0].size() + done_q[1].size());
            for (int i = 0; i < 2; i++) begin
                exp_q[i].delete();
                done_q[i].delete();
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (n_plot[i] != exp_n[i]) begin
                n_fail++;
                $display("FAIL %s_plot_count dut=%0d got %0d want %0d", tag, i, n_plot[i], exp_n[i]);
            end
        end
        repeat (4) step();
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 2048; k++) rom_mem[k] = 3'(k);
    endtask

    initial begin
        int c;
        resetn = 1'b0;
        start  = 1'b0;
        x_base = '0;
        y_base = '0;
        for (int i = 0; i < 2; i++) begin
            b_lo[i]   = 1;
            b_hi[i]   = 0;
            n_plot[i] = 0;
            exp_n[i]  = 0;
        end
        fill_ramp();
        repeat (3) step();
        resetn = 1'b1;
        repeat (3) step();

        issue(0, 0, c);     wait_end("basic");
        issue(150, 100, c); wait_end("clip");
        issue(120, 80, c);  wait_end("edge_fit");
        issue(121, 81, c);  wait_end("edge_clip");
        issue(255, 127, c); wait_end("all_clipped");

        issue(20, 30, c);
        while (cyc < c + 800) step();
        start  = 1'b1;
        x_base = 8'($urandom_range(0, 255));
        y_base = 7'($urandom_range(0, 127));
        step();
        start = 1'b0;
        wait_end("busy_start");

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 2048; k++) rom_mem[k] = 3'($urandom_range(0, 7));
            issue(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)), c);
            wait_end("random");
        end

        fill_ramp();
        issue(10, 10, c);
        while (cyc < c + 500) step();
        resetn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            b_lo[i] = 1;
            b_hi[i] = 0;
            n_cmp++;
            if (!outs_zero[i]) begin
                n_fail++;
                $display("FAIL reset_immediate dut=%0d got nonzero outputs want all zero", i);
            end
        end
        step();
        step();
        resetn = 1'b1;
        repeat (20) step();
        issue(5, 7, c);     wait_end("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
